// File: rtl/game_flow_controller.sv
// Screen-flow sequencer: start -> level -> win/game-over, with debounced start
// button, lives tracking and a blanked multi-frame transition between screens.
module game_flow_controller #(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned TRANSITION_FRAMES = 30,
  parameter int unsigned START_LIVES       = 3
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       start_button,
  input  logic       level_win,
  input  logic       level_lose,
  output logic [3:0] screen_select,
  output logic       blank,
  output logic       level_run,
  output logic       level_restart,
  output logic [1:0] lives
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FR_W = (TRANSITION_FRAMES > 1) ? $clog2(TRANSITION_FRAMES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(TRANSITION_FRAMES - 1);
  localparam logic [1:0]      LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [2:0] {S_START, S_TRANS, S_LEVEL, S_WIN, S_OVER} state_t;
  // Encoding doubles as the bit index of the target screen in screen_select.
  typedef enum logic [1:0] {T_START, T_LEVEL, T_WIN, T_OVER} target_t;

  logic            sync_1, sync_2, db_level, press;
  logic [DB_W-1:0] db_count;

  state_t          state, state_n;
  target_t         target, target_n;
  logic [FR_W-1:0] frame_cnt, frame_cnt_n;
  logic [1:0]      lives_n;
  logic [3:0]      select_n;
  logic            blank_n, run_n, restart_n;

  always_ff @(posedge vga_clock) begin
    if (!reset) begin
      sync_1   <= 1'b1;
      sync_2   <= 1'b1;
      db_level <= 1'b1;
      db_count <= '0;
      press    <= 1'b0;
    end else begin
      sync_1 <= start_button;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 != db_level) begin
        if (db_count == DB_LAST) begin
          db_level <= sync_2;
          db_count <= '0;
          press    <= ~sync_2;
        end else begin
          db_count <= db_count + 1'b1;
        end
      end else begin
        db_count <= '0;
      end
    end
  end

  always_comb begin
    state_n     = state;
    target_n    = target;
    frame_cnt_n = frame_cnt;
    lives_n     = lives;
    case (state)
      S_START: if (press) begin
        state_n     = S_TRANS;
        target_n    = T_LEVEL;
        frame_cnt_n = '0;
        lives_n     = LIVES_INIT;
      end
      S_TRANS: if (frame_start) begin
        if (frame_cnt == FR_LAST) begin
          case (target)
            T_START: state_n = S_START;
            T_LEVEL: state_n = S_LEVEL;
            T_WIN:   state_n = S_WIN;
            default: state_n = S_OVER;
          endcase
        end else begin
          frame_cnt_n = frame_cnt + 1'b1;
        end
      end
      S_LEVEL: begin
        if (level_win) begin
          state_n     = S_TRANS;
          target_n    = T_WIN;
          frame_cnt_n = '0;
        end else if (level_lose) begin
          state_n     = S_TRANS;
          frame_cnt_n = '0;
          if (lives > 2'd1) begin
            lives_n  = lives - 2'd1;
            target_n = T_LEVEL;
          end else begin
            lives_n  = '0;
            target_n = T_OVER;
          end
        end
      end
      S_WIN, S_OVER: if (press) begin
        state_n     = S_TRANS;
        target_n    = T_START;
        frame_cnt_n = '0;
      end
      default: state_n = S_START;
    endcase
  end

  always_comb begin
    select_n  = 4'b0001;
    blank_n   = 1'b0;
    run_n     = 1'b0;
    restart_n = 1'b0;
    case (state)
      S_TRANS: begin
        select_n  = 4'b0001 << target;
        blank_n   = 1'b1;
        restart_n = (target == T_LEVEL);
      end
      S_LEVEL: begin
        select_n = 4'b0010;
        run_n    = 1'b1;
      end
      S_WIN:   select_n = 4'b0100;
      S_OVER:  select_n = 4'b1000;
      default: select_n = 4'b0001;
    endcase
  end

  always_ff @(posedge vga_clock) begin
    if (!reset) begin
      state         <= S_START;
      target        <= T_START;
      frame_cnt     <= '0;
      lives         <= '0;
      screen_select <= 4'b0001;
      blank         <= 1'b0;
      level_run     <= 1'b0;
      level_restart <= 1'b0;
    end else begin
      state         <= state_n;
      target        <= target_n;
      frame_cnt     <= frame_cnt_n;
      lives         <= lives_n;
      screen_select <= select_n;
      blank         <= blank_n;
      level_run     <= run_n;
      level_restart <= restart_n;
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with small debounce/transition parameters.
module tb_game_flow_controller;

  logic       vga_clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       start_button = 1'b1;
  logic       level_win = 1'b0;
  logic       level_lose = 1'b0;
  logic [3:0] screen_select;
  logic       blank, level_run, level_restart;
  logic [1:0] lives;

  int checks = 0;
  int errors = 0;

  game_flow_controller #(
    .DEBOUNCE_CYCLES(4),
    .TRANSITION_FRAMES(2),
    .START_LIVES(3)
  ) dut (
    .vga_clock(vga_clock),
    .reset(reset),
    .frame_start(frame_start),
    .start_button(start_button),
    .level_win(level_win),
    .level_lose(level_lose),
    .screen_select(screen_select),
    .blank(blank),
    .level_run(level_run),
    .level_restart(level_restart),
    .lives(lives)
  );

  always #5 vga_clock = ~vga_clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge vga_clock);
      #1;
    end
  endtask

  task automatic frame_pulse(input int gap);
    tick(gap);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic press_and_release();
    start_button = 1'b0;
    tick(10);
    start_button = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    checks++;
    if ({screen_select, blank, level_run, level_restart, lives} !== {4'b0001, 3'b000, 2'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%b blank=%b run=%b rst=%b lives=%0d, need 0001/0/0/0/0",
               screen_select, blank, level_run, level_restart, lives);
    end
  endtask

  task automatic test_glitch_and_start_ignores();
    start_button = 1'b0;
    tick(3);
    start_button = 1'b1;
    tick(8);
    checks++;
    if (screen_select !== 4'b0001 || blank !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got sel=%b blank=%b, need 0001/0", screen_select, blank);
    end
    level_win = 1'b1;
    tick();
    level_win = 1'b0;
    level_lose = 1'b1;
    tick();
    level_lose = 1'b0;
    tick(3);
    checks++;
    if (screen_select !== 4'b0001 || blank !== 1'b0 || lives !== 2'd0) begin
      errors++;
      $display("FAIL start_ignores_level: got sel=%b blank=%b lives=%0d, need 0001/0/0",
               screen_select, blank, lives);
    end
  endtask

  task automatic test_start_game();
    start_button = 1'b0;
    tick(10);
    checks++;
    if ({screen_select, blank, level_run, level_restart, lives} !== {4'b0010, 3'b101, 2'd3}) begin
      errors++;
      $display("FAIL start_trans: got sel=%b blank=%b run=%b rst=%b lives=%0d, need 0010/1/0/1/3",
               screen_select, blank, level_run, level_restart, lives);
    end
    start_button = 1'b1;
    tick(8);
    frame_pulse(2);
    checks++;
    if (blank !== 1'b1) begin
      errors++;
      $display("FAIL trans_one_frame: got blank=%b, need 1", blank);
    end
    frame_pulse(5);
    checks++;
    if (blank !== 1'b1 || level_run !== 1'b0) begin
      errors++;
      $display("FAIL trans_exit_latency: got blank=%b run=%b, need 1/0", blank, level_run);
    end
    tick();
    checks++;
    if ({screen_select, blank, level_run, level_restart} !== {4'b0010, 3'b010}) begin
      errors++;
      $display("FAIL enter_level: got sel=%b blank=%b run=%b rst=%b, need 0010/0/1/0",
               screen_select, blank, level_run, level_restart);
    end
  endtask

  task automatic test_press_in_level();
    press_and_release();
    checks++;
    if ({screen_select, blank, level_run, lives} !== {4'b0010, 2'b01, 2'd3}) begin
      errors++;
      $display("FAIL press_in_level: got sel=%b blank=%b run=%b lives=%0d, need 0010/0/1/3",
               screen_select, blank, level_run, lives);
    end
  endtask

  task automatic test_lose_lives();
    level_lose = 1'b1;
    tick();
    level_lose = 1'b0;
    checks++;
    if (lives !== 2'd2 || level_run !== 1'b1) begin
      errors++;
      $display("FAIL lose1_edge: got lives=%0d run=%b, need 2/1", lives, level_run);
    end
    tick();
    checks++;
    if ({screen_select, blank, level_run, level_restart} !== {4'b0010, 3'b101}) begin
      errors++;
      $display("FAIL lose1_trans: got sel=%b blank=%b run=%b rst=%b, need 0010/1/0/1",
               screen_select, blank, level_run, level_restart);
    end
    press_and_release();
    checks++;
    if (blank !== 1'b1 || screen_select !== 4'b0010) begin
      errors++;
      $display("FAIL press_in_trans: got sel=%b blank=%b, need 0010/1", screen_select, blank);
    end
    frame_pulse(3);
    frame_pulse(3);
    tick();
    checks++;
    if (level_run !== 1'b1 || blank !== 1'b0) begin
      errors++;
      $display("FAIL lose1_back: got run=%b blank=%b, need 1/0", level_run, blank);
    end

    level_lose = 1'b1;
    tick();
    level_lose = 1'b0;
    checks++;
    if (lives !== 2'd1) begin
      errors++;
      $display("FAIL lose2_lives: got %0d, need 1", lives);
    end
    frame_pulse(3);
    frame_pulse(3);
    tick();

    level_lose = 1'b1;
    tick();
    level_lose = 1'b0;
    tick();
    checks++;
    if ({screen_select, blank, level_run, level_restart, lives} !== {4'b1000, 3'b100, 2'd0}) begin
      errors++;
      $display("FAIL lose3_trans: got sel=%b blank=%b run=%b rst=%b lives=%0d, need 1000/1/0/0/0",
               screen_select, blank, level_run, level_restart, lives);
    end
    frame_pulse(3);
    frame_pulse(3);
    tick();
    checks++;
    if (screen_select !== 4'b1000 || blank !== 1'b0) begin
      errors++;
      $display("FAIL over_screen: got sel=%b blank=%b, need 1000/0", screen_select, blank);
    end
  endtask

  task automatic test_over_held_button();
    level_win = 1'b1;
    level_lose = 1'b1;
    tick();
    level_win = 1'b0;
    level_lose = 1'b0;
    tick(2);
    checks++;
    if (screen_select !== 4'b1000 || blank !== 1'b0 || lives !== 2'd0) begin
      errors++;
      $display("FAIL over_ignores_level: got sel=%b blank=%b lives=%0d, need 1000/0/0",
               screen_select, blank, lives);
    end
    start_button = 1'b0;
    tick(10);
    checks++;
    if ({screen_select, blank, level_restart, lives} !== {4'b0001, 2'b10, 2'd0}) begin
      errors++;
      $display("FAIL over_press: got sel=%b blank=%b rst=%b lives=%0d, need 0001/1/0/0",
               screen_select, blank, level_restart, lives);
    end
    frame_pulse(2);
    frame_pulse(2);
    tick();
    tick(12);
    checks++;
    if (screen_select !== 4'b0001 || blank !== 1'b0) begin
      errors++;
      $display("FAIL held_single_press: got sel=%b blank=%b, need 0001/0", screen_select, blank);
    end
    start_button = 1'b1;
    tick(8);
  endtask

  task automatic test_win_priority();
    press_and_release();
    frame_pulse(3);
    frame_pulse(3);
    tick();
    level_win = 1'b1;
    level_lose = 1'b1;
    tick();
    level_win = 1'b0;
    level_lose = 1'b0;
    tick();
    checks++;
    if ({screen_select, blank, level_restart, lives} !== {4'b0100, 2'b10, 2'd3}) begin
      errors++;
      $display("FAIL win_priority: got sel=%b blank=%b rst=%b lives=%0d, need 0100/1/0/3",
               screen_select, blank, level_restart, lives);
    end
    frame_pulse(3);
    frame_pulse(3);
    tick();
    level_lose = 1'b1;
    tick();
    level_lose = 1'b0;
    tick(2);
    checks++;
    if ({screen_select, blank, level_run, lives} !== {4'b0100, 2'b00, 2'd3}) begin
      errors++;
      $display("FAIL win_screen: got sel=%b blank=%b run=%b lives=%0d, need 0100/0/0/3",
               screen_select, blank, level_run, lives);
    end
  endtask

  task automatic test_frame_on_entry();
    start_button = 1'b0;
    tick(7);
    checks++;
    if (screen_select !== 4'b0100 || blank !== 1'b0) begin
      errors++;
      $display("FAIL entry_latency: got sel=%b blank=%b, need 0100/0", screen_select, blank);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    checks++;
    if (screen_select !== 4'b0001 || blank !== 1'b1) begin
      errors++;
      $display("FAIL entry_trans: got sel=%b blank=%b, need 0001/1", screen_select, blank);
    end
    frame_pulse(3);
    tick();
    checks++;
    if (screen_select !== 4'b0001 || blank !== 1'b0 || lives !== 2'd3) begin
      errors++;
      $display("FAIL entry_frame_counted: got sel=%b blank=%b lives=%0d, need 0001/0/3",
               screen_select, blank, lives);
    end
    start_button = 1'b1;
    tick(8);
  endtask

  task automatic test_reset_mid_trans();
    press_and_release();
    frame_pulse(2);
    reset = 1'b0;
    tick();
    checks++;
    if ({screen_select, blank, level_run, level_restart, lives} !== {4'b0001, 3'b000, 2'd0}) begin
      errors++;
      $display("FAIL reset_mid_trans: got sel=%b blank=%b run=%b rst=%b lives=%0d, need 0001/0/0/0/0",
               screen_select, blank, level_run, level_restart, lives);
    end
    reset = 1'b1;
    frame_pulse(3);
    frame_pulse(3);
    tick(5);
    checks++;
    if (screen_select !== 4'b0001 || blank !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: got sel=%b blank=%b, need 0001/0", screen_select, blank);
    end
  endtask

  initial begin
    test_reset();
    test_glitch_and_start_ignores();
    test_start_game();
    test_press_in_level();
    test_lose_lives();
    test_over_held_button();
    test_win_priority();
    test_frame_on_entry();
    test_reset_mid_trans();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
